sd_sector_buf: RTL and testbench

- Downstream consumer of the SD initialisation/read engine; drives the read handshake into it.
- Requests one 512-byte sector read via `sd_ren` and captures the byte stream (`miso_data` qualified by `wclk`).
- Discards the 2 trailing CRC bytes, buffers the data, then drains it to the UART transmit path over a valid/ready handshake.
- Generates the `fifo_busy` acknowledge that the engine waits on after init and after each read.

---
 rtl/sd_sector_buf_if.sv | 11 +
 rtl/sd_sector_buf.sv | 206 ++++++++++++++++++++
 tb/tb_sd_sector_buf.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sd_sector_buf_if.sv
// Byte stream from the sector buffer to the UART transmit path.
// The master side drives data/valid and the slave side returns ready.
`timescale 1ns/1ps
interface sd_sector_buf_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/sd_sector_buf.sv
// Single-sector buffer between the SD read engine and the UART transmit path.
// Optional CRC16-CCITT check of the received sector is enabled by defining SD_SECT_CRC_CHK_EN.
`timescale 1ns/1ps
module sd_sector_buf #(
    parameter int SECT_BYTES = 512,
    parameter int AW         = 9,
    parameter int ACK_CYC    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic                  i_init_ok,
    output logic                  o_sd_ren,
    input  logic                  i_wclk,
    input  logic [7:0]            i_miso_data,
    input  logic                  i_rd_ok,
    output logic                  o_fifo_busy,
    sd_sector_buf_if.master       tx_if,
    output logic                  o_sector_done,
    output logic                  o_len_err,
    output logic                  o_crc_err
);

    localparam int ACKW = $clog2(ACK_CYC);
    localparam logic [9:0] SECT_N = 10'(SECT_BYTES);
    localparam logic [9:0] CRC_HI = 10'(SECT_BYTES);
    localparam logic [9:0] CRC_LO = 10'(SECT_BYTES + 1);
    localparam logic [9:0] LEN_OK = 10'(SECT_BYTES + 2);

    typedef enum logic [2:0] {IDLE, INIT_ACK, REQ, FILL, HOLD, DRAIN} state_t;

    state_t          r_state;
    logic            r_wclk_d, r_rdok_d, r_init_d;
    logic [ACKW-1:0] r_ack_cnt;
    logic [9:0]      r_bc;
    logic [AW:0]     r_wr_ptr, r_rd_ptr;
    logic            r_sd_ren, r_fifo_busy, r_tx_valid, r_done, r_len_err;
    logic [7:0]      r_rd_data;
    logic [7:0]      r_mem [0:(1<<AW)-1];

    logic            w_bs, w_rdok_r, w_ini_r, w_wr_en, w_fire, w_start_go, w_len_bad;
    logic [9:0]      w_bc_next;
    logic [AW-1:0]   w_rd_addr;

    assign w_bs       = i_wclk & ~r_wclk_d;
    assign w_rdok_r   = i_rd_ok & ~r_rdok_d;
    assign w_ini_r    = i_init_ok & ~r_init_d;
    assign w_start_go = (r_state == IDLE) && !w_ini_r && i_start && i_init_ok;
    assign w_wr_en    = w_bs && ((r_state == REQ) || ((r_state == FILL) && (r_bc < SECT_N)));
    assign w_bc_next  = (w_bs && (r_bc != 10'h3FF)) ? r_bc + 10'd1 : r_bc;
    assign w_len_bad  = (w_bc_next != LEN_OK);
    assign w_fire     = (r_state == DRAIN) && r_tx_valid && tx_if.tx_ready;
    // Look one address ahead on an accept so the next byte follows without a bubble.
    assign w_rd_addr  = w_fire ? r_rd_ptr[AW-1:0] + AW'(1) : r_rd_ptr[AW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wclk_d <= 1'b0;
            r_rdok_d <= 1'b0;
            r_init_d <= 1'b0;
        end else begin
            r_wclk_d <= i_wclk;
            r_rdok_d <= i_rd_ok;
            r_init_d <= i_init_ok;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= i_miso_data;
    end

    always_ff @(posedge clk) begin
        if (rst)                    r_rd_data <= 8'h00;
        else if (r_state == DRAIN)  r_rd_data <= r_mem[w_rd_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ack_cnt   <= '0;
            r_bc        <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_sd_ren    <= 1'b0;
            r_fifo_busy <= 1'b0;
            r_tx_valid  <= 1'b0;
            r_done      <= 1'b0;
            r_len_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            case (r_state)
                IDLE: begin
                    if (w_ini_r) begin
                        r_fifo_busy <= 1'b1;
                        r_ack_cnt   <= ACKW'(ACK_CYC - 1);
                        r_state     <= INIT_ACK;
                    end else if (w_start_go) begin
                        r_len_err <= 1'b0;
                        r_bc      <= '0;
                        r_wr_ptr  <= '0;
                        r_rd_ptr  <= '0;
                        r_sd_ren  <= 1'b1;
                        r_state   <= REQ;
                    end
                end
                INIT_ACK: begin
                    if (r_ack_cnt == '0) begin
                        r_fifo_busy <= 1'b0;
                        r_state     <= IDLE;
                    end else begin
                        r_ack_cnt <= r_ack_cnt - ACKW'(1);
                    end
                end
                REQ: begin
                    if (w_bs) begin
                        r_sd_ren <= 1'b0;
                        r_bc     <= 10'd1;
                        r_state  <= FILL;
                    end
                end
                FILL: begin
                    r_bc <= w_bc_next;
                    // A strobe landing with the rd_ok edge is already folded into w_bc_next.
                    if (w_rdok_r) begin
                        r_fifo_busy <= 1'b1;
                        r_len_err   <= w_len_bad;
                        r_rd_ptr    <= '0;
                        r_state     <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!r_tx_valid) begin
                        if (r_rd_ptr == r_wr_ptr) begin
                            r_done  <= 1'b1;
                            r_state <= HOLD;
                        end else begin
                            r_tx_valid <= 1'b1;
                        end
                    end else if (tx_if.tx_ready) begin
                        r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
                        if (r_rd_ptr + (AW+1)'(1) == r_wr_ptr) begin
                            r_tx_valid <= 1'b0;
                            r_done     <= 1'b1;
                            r_state    <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (!i_rd_ok) begin
                        r_fifo_busy <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef SD_SECT_CRC_CHK_EN
    logic [15:0] r_crc, r_rx_crc, w_crc_next, w_rx_next;
    logic        r_crc_err;

    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] x;
        x = c ^ {d, 8'h00};
        for (int k = 0; k < 8; k++) x = x[15] ? ((x << 1) ^ 16'h1021) : (x << 1);
        return x;
    endfunction

    always_comb begin
        w_crc_next = r_crc;
        w_rx_next  = r_rx_crc;
        if (w_wr_en) w_crc_next = crc_byte(r_crc, i_miso_data);
        if (w_bs && (r_state == FILL)) begin
            if (r_bc == CRC_HI)      w_rx_next[15:8] = i_miso_data;
            else if (r_bc == CRC_LO) w_rx_next[7:0]  = i_miso_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_start_go) begin
            r_crc     <= '0;
            r_rx_crc  <= '0;
            r_crc_err <= 1'b0;
        end else begin
            r_crc    <= w_crc_next;
            r_rx_crc <= w_rx_next;
            if ((r_state == FILL) && w_rdok_r)
                r_crc_err <= (w_crc_next != w_rx_next) || w_len_bad;
        end
    end

    assign o_crc_err = r_crc_err;
`else
    assign o_crc_err = 1'b0;
`endif

    assign o_sd_ren        = r_sd_ren;
    assign o_fifo_busy     = r_fifo_busy;
    assign o_sector_done   = r_done;
    assign o_len_err       = r_len_err;
    assign tx_if.tx_data   = r_rd_data;
    assign tx_if.tx_valid  = r_tx_valid;

endmodule

// File: tb/tb_sd_sector_buf.sv
// Directed self-checking bench for sd_sector_buf: init acknowledge, full/stalled/short
// sectors, HOLD release and (with SD_SECT_CRC_CHK_EN) the CRC check.
`timescale 1ns/1ps
module tb_sd_sector_buf;

`ifdef SD_SECT_CRC_CHK_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       initOk = 1'b0;
    logic       wclk = 1'b0;
    logic       rdOk = 1'b0;
    logic [7:0] misoData = 8'h00;
    logic       sdRen, fifoBusy, sectorDone, lenErr, crcErr;

    sd_sector_buf_if txIf();

    int checkCount = 0;
    int errorCount = 0;

    logic [7:0] rxBytes [0:1023];
    int  rxCount, doneCnt;
    bit  stableOk, timedOut, sdRenSeen, busyLowSeen, validAfterDone;

    always #5 clk = ~clk;

    sd_sector_buf #(.SECT_BYTES(512), .AW(9), .ACK_CYC(32)) dut (
        .clk(clk), .rst(rst), .i_start(start), .i_init_ok(initOk), .o_sd_ren(sdRen),
        .i_wclk(wclk), .i_miso_data(misoData), .i_rd_ok(rdOk), .o_fifo_busy(fifoBusy),
        .tx_if(txIf), .o_sector_done(sectorDone), .o_len_err(lenErr), .o_crc_err(crcErr)
    );

    task automatic sendByte(input logic [7:0] d);
        @(negedge clk); wclk = 1'b1; misoData = d;
        @(negedge clk); wclk = 1'b0;
    endtask

    task automatic sendRange(input int first, input int last, input bit zeroData);
        for (int i = first; i <= last; i++) sendByte(zeroData ? 8'h00 : 8'(i));
    endtask

    task automatic pulseStart();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic raiseRdOk();
        @(negedge clk); rdOk = 1'b1;
    endtask

    task automatic endSector();
        @(negedge clk); rdOk = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Collects the drained bytes and handshake observations; tests judge the results.
    task automatic drainSector(input int readyMode, input int startAt);
        bit         prevStall, ready;
        logic [7:0] prevData;
        int         post;
        rxCount = 0; doneCnt = 0; stableOk = 1; timedOut = 1;
        sdRenSeen = 0; busyLowSeen = 0; validAfterDone = 0;
        prevStall = 0; prevData = 8'h00; post = 0;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            @(negedge clk);
            start = (cyc == startAt);
            if (sdRen) sdRenSeen = 1;
            if (!fifoBusy) busyLowSeen = 1;
            if (prevStall && (txIf.tx_valid !== 1'b1 || txIf.tx_data !== prevData)) stableOk = 0;
            if (doneCnt > 0 && txIf.tx_valid) validAfterDone = 1;
            if (sectorDone) doneCnt++;
            if (doneCnt > 0) begin
                post++;
                if (post > 5) begin
                    timedOut = 0;
                    break;
                end
            end
            ready = (readyMode == 0) ? 1'b1 : (cyc % 3 == 0);
            txIf.tx_ready = ready;
            if (txIf.tx_valid && ready) begin
                if (rxCount < 1024) rxBytes[rxCount] = txIf.tx_data;
                rxCount++;
            end
            prevStall = txIf.tx_valid && !ready;
            prevData  = txIf.tx_data;
        end
        start = 1'b0;
        txIf.tx_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkCount++; if (sdRen !== 1'b0) begin errorCount++; $display("[TB] FAIL rst_sd_ren got %b exp 0", sdRen); end
        checkCount++; if (fifoBusy !== 1'b0) begin errorCount++; $display("[TB] FAIL rst_fifo_busy got %b exp 0", fifoBusy); end
        checkCount++; if (txIf.tx_valid !== 1'b0) begin errorCount++; $display("[TB] FAIL rst_tx_valid got %b exp 0", txIf.tx_valid); end
        checkCount++; if (txIf.tx_data !== 8'h00) begin errorCount++; $display("[TB] FAIL rst_tx_data got %h exp 00", txIf.tx_data); end
        checkCount++; if (sectorDone !== 1'b0) begin errorCount++; $display("[TB] FAIL rst_sector_done got %b exp 0", sectorDone); end
        checkCount++; if (lenErr !== 1'b0) begin errorCount++; $display("[TB] FAIL rst_len_err got %b exp 0", lenErr); end
        checkCount++; if (crcErr !== 1'b0) begin errorCount++; $display("[TB] FAIL rst_crc_err got %b exp 0", crcErr); end
    endtask

    task automatic test_init();
        int  highCnt;
        bit  stray;
        highCnt = 0; stray = 0;
        pulseStart();
        checkCount++; if (sdRen !== 1'b0) begin errorCount++; $display("[TB] FAIL start_without_init got sd_ren %b exp 0", sdRen); end
        @(negedge clk); initOk = 1'b1;
        for (int cyc = 0; cyc < 100; cyc++) begin
            @(negedge clk);
            if (fifoBusy) highCnt++;
            if (sdRen || txIf.tx_valid) stray = 1;
        end
        checkCount++; if (highCnt != 32) begin errorCount++; $display("[TB] FAIL init_ack_len got %0d exp 32", highCnt); end
        checkCount++; if (fifoBusy !== 1'b0) begin errorCount++; $display("[TB] FAIL init_ack_end got %b exp 0", fifoBusy); end
        checkCount++; if (stray !== 1'b0) begin errorCount++; $display("[TB] FAIL init_stray_out got %b exp 0", stray); end
    endtask

    task automatic test_full();
        int bad;
        pulseStart();
        checkCount++; if (sdRen !== 1'b1) begin errorCount++; $display("[TB] FAIL full_sd_ren_req got %b exp 1", sdRen); end
        sendByte(8'h00);
        checkCount++; if (sdRen !== 1'b0) begin errorCount++; $display("[TB] FAIL full_sd_ren_drop got %b exp 0", sdRen); end
        sendRange(1, 511, 1'b0);
        sendByte(8'hAB); sendByte(8'hCD);
        raiseRdOk();
        drainSector(0, -1);
        bad = -1;
        for (int i = 0; i < 512; i++) if (rxBytes[i] !== 8'(i)) begin bad = i; break; end
        checkCount++; if (timedOut) begin errorCount++; $display("[TB] FAIL full_timeout got 1 exp 0"); end
        checkCount++; if (rxCount != 512) begin errorCount++; $display("[TB] FAIL full_count got %0d exp 512", rxCount); end
        checkCount++; if (bad != -1) begin errorCount++; $display("[TB] FAIL full_data idx %0d got %h exp %h", bad, rxBytes[bad], 8'(bad)); end
        checkCount++; if (doneCnt != 1) begin errorCount++; $display("[TB] FAIL full_done_pulses got %0d exp 1", doneCnt); end
        checkCount++; if (busyLowSeen) begin errorCount++; $display("[TB] FAIL full_busy_drain got low exp high"); end
        checkCount++; if (validAfterDone) begin errorCount++; $display("[TB] FAIL full_valid_after_done got 1 exp 0"); end
        checkCount++; if (lenErr !== 1'b0) begin errorCount++; $display("[TB] FAIL full_len_err got %b exp 0", lenErr); end
        endSector();
        checkCount++; if (fifoBusy !== 1'b0) begin errorCount++; $display("[TB] FAIL full_busy_release got %b exp 0", fifoBusy); end
    endtask

    task automatic test_back_to_back();
        int bad;
        pulseStart();
        sendRange(0, 511, 1'b0);
        sendByte(8'h55); sendByte(8'hAA);
        raiseRdOk();
        drainSector(1, -1);
        bad = -1;
        for (int i = 0; i < 512; i++) if (rxBytes[i] !== 8'(i)) begin bad = i; break; end
        checkCount++; if (timedOut) begin errorCount++; $display("[TB] FAIL stall_timeout got 1 exp 0"); end
        checkCount++; if (rxCount != 512) begin errorCount++; $display("[TB] FAIL stall_count got %0d exp 512", rxCount); end
        checkCount++; if (bad != -1) begin errorCount++; $display("[TB] FAIL stall_data idx %0d got %h exp %h", bad, rxBytes[bad], 8'(bad)); end
        checkCount++; if (!stableOk) begin errorCount++; $display("[TB] FAIL stall_hold_stable got 0 exp 1"); end
        checkCount++; if (doneCnt != 1) begin errorCount++; $display("[TB] FAIL stall_done_pulses got %0d exp 1", doneCnt); end
        endSector();
    endtask

    task automatic test_short();
        int bad;
        pulseStart();
        sendRange(0, 299, 1'b0);
        raiseRdOk();
        drainSector(0, -1);
        bad = -1;
        for (int i = 0; i < 300; i++) if (rxBytes[i] !== 8'(i)) begin bad = i; break; end
        checkCount++; if (timedOut) begin errorCount++; $display("[TB] FAIL short_timeout got 1 exp 0"); end
        checkCount++; if (rxCount != 300) begin errorCount++; $display("[TB] FAIL short_count got %0d exp 300", rxCount); end
        checkCount++; if (bad != -1) begin errorCount++; $display("[TB] FAIL short_data idx %0d got %h exp %h", bad, rxBytes[bad], 8'(bad)); end
        checkCount++; if (doneCnt != 1) begin errorCount++; $display("[TB] FAIL short_done_pulses got %0d exp 1", doneCnt); end
        checkCount++; if (lenErr !== 1'b1) begin errorCount++; $display("[TB] FAIL short_len_err got %b exp 1", lenErr); end
        checkCount++; if (crcErr !== CRC_EN) begin errorCount++; $display("[TB] FAIL short_crc_err got %b exp %b", crcErr, CRC_EN); end
        endSector();
    endtask

    task automatic test_hold();
        int lowCnt;
        bit renAgain;
        lowCnt = 0; renAgain = 0;
        pulseStart();
        checkCount++; if (lenErr !== 1'b0) begin errorCount++; $display("[TB] FAIL hold_len_err_clear got %b exp 0", lenErr); end
        sendRange(0, 511, 1'b0);
        sendByte(8'h00); sendByte(8'h00);
        raiseRdOk();
        drainSector(0, 5);
        checkCount++; if (rxCount != 512) begin errorCount++; $display("[TB] FAIL hold_count got %0d exp 512", rxCount); end
        checkCount++; if (sdRenSeen) begin errorCount++; $display("[TB] FAIL hold_start_in_drain got sd_ren 1 exp 0"); end
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (!fifoBusy) lowCnt++;
        end
        checkCount++; if (lowCnt != 0) begin errorCount++; $display("[TB] FAIL hold_busy_low_cycles got %0d exp 0", lowCnt); end
        rdOk = 1'b0;
        @(negedge clk);
        checkCount++; if (fifoBusy !== 1'b0) begin errorCount++; $display("[TB] FAIL hold_busy_release got %b exp 0", fifoBusy); end
        repeat (5) begin
            @(negedge clk);
            if (sdRen) renAgain = 1;
        end
        checkCount++; if (renAgain) begin errorCount++; $display("[TB] FAIL hold_late_start got sd_ren 1 exp 0"); end
    endtask

    task automatic test_crc();
        pulseStart();
        checkCount++; if (crcErr !== 1'b0) begin errorCount++; $display("[TB] FAIL crc_clear_on_start got %b exp 0", crcErr); end
        sendRange(0, 511, 1'b1);
        sendByte(8'h00); sendByte(8'h00);
        raiseRdOk();
        drainSector(0, -1);
        checkCount++; if (rxCount != 512) begin errorCount++; $display("[TB] FAIL crc_zero_count got %0d exp 512", rxCount); end
        checkCount++; if (crcErr !== 1'b0) begin errorCount++; $display("[TB] FAIL crc_zero_ok got %b exp 0", crcErr); end
        checkCount++; if (lenErr !== 1'b0) begin errorCount++; $display("[TB] FAIL crc_zero_len got %b exp 0", lenErr); end
        endSector();
        pulseStart();
        sendRange(0, 511, 1'b1);
        sendByte(8'h12); sendByte(8'h34);
        raiseRdOk();
        drainSector(0, -1);
        checkCount++; if (crcErr !== CRC_EN) begin errorCount++; $display("[TB] FAIL crc_bad_detect got %b exp %b", crcErr, CRC_EN); end
        checkCount++; if (lenErr !== 1'b0) begin errorCount++; $display("[TB] FAIL crc_bad_len got %b exp 0", lenErr); end
        endSector();
    endtask

    initial begin
        txIf.tx_ready = 1'b0;
        $display("[TB] starting sd_sector_buf bench (crc check %0d)", CRC_EN);
        test_reset();
        test_init();
        test_full();
        test_back_to_back();
        test_short();
        test_hold();
        test_crc();
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
